// File: rtl/shift_reg_tap.sv
// shift_reg_tap: WIDTH x DEPTH delay line with per-stage valid bits, a
// pipeline-wide stall, a synchronous flush and a runtime-selected tap.
//
// Ports:
//   clk, rstn        clock (rising edge), async active-low reset
//   en               shift enable; 0 holds all state
//   flush            synchronous clear of every stage; wins over en
//   valid_in/data_in input word and qualifier (data gated to 0 when invalid)
//   tap_sel          stage index for tap_data/tap_valid (combinational mux)
//   data_out/valid_out  last stage, straight from registers
//   fill_cnt         number of valid stages (registered)
//   full             fill_cnt == DEPTH
//   win_sum          (only with SHIFT_REG_TAP_SUM_EN defined) running sum
//                    of all stage data, i.e. moving-window sum
//
// Optional feature macro: SHIFT_REG_TAP_SUM_EN.

// One delay stage: data plus valid, cleared on flush, held on stall.
module shift_reg_tap_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] d_q,
  output logic             v_q
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_q <= '0;
      v_q <= 1'b0;
    end else if (flush) begin
      d_q <= '0;
      v_q <= 1'b0;
    end else if (en) begin
      d_q <= d_in;
      v_q <= v_in;
    end
  end
endmodule

module shift_reg_tap #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int TSW   = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic [TSW-1:0]   tap_sel,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] tap_data,
  output logic             tap_valid,
  output logic [CW-1:0]    fill_cnt,
  output logic             full
`ifdef SHIFT_REG_TAP_SUM_EN
  ,
  output logic [WIDTH+CW-1:0] win_sum
`endif
);

  logic [DEPTH-1:0][WIDTH-1:0] d, d_nxt;
  logic [DEPTH-1:0]            vld_pipe, v_nxt;
  logic [WIDTH-1:0]            data_gated;

  // Invalid slots always carry zero data so the tap and sum never see stale words.
  assign data_gated = valid_in ? data_in : '0;
  assign d_nxt[0]   = data_gated;
  assign v_nxt[0]   = valid_in;

  for (genvar i = 1; i < DEPTH; i++) begin : g_link
    assign d_nxt[i] = d[i-1];
    assign v_nxt[i] = vld_pipe[i-1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    shift_reg_tap_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rstn  (rstn),
      .en    (en),
      .flush (flush),
      .d_in  (d_nxt[i]),
      .v_in  (v_nxt[i]),
      .d_q   (d[i]),
      .v_q   (vld_pipe[i])
    );
  end

  assign data_out  = d[DEPTH-1];
  assign valid_out = vld_pipe[DEPTH-1];

  // Decoded mux: tap_sel values >= DEPTH match no stage and read as zero.
  always_comb begin
    tap_data  = '0;
    tap_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TSW'(i)) begin
        tap_data  = d[i];
        tap_valid = vld_pipe[i];
      end
    end
  end

  // Occupancy tracks popcount(vld_pipe): a word entering and one leaving cancel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill_cnt <= '0;
    end else if (flush) begin
      fill_cnt <= '0;
    end else if (en) begin
      if (valid_in && !vld_pipe[DEPTH-1])
        fill_cnt <= fill_cnt + CW'(1);
      else if (!valid_in && vld_pipe[DEPTH-1])
        fill_cnt <= fill_cnt - CW'(1);
    end
  end

  assign full = (fill_cnt == CW'(DEPTH));

`ifdef SHIFT_REG_TAP_SUM_EN
  localparam int SW = WIDTH + CW;
  // Incremental window sum: add the entering word, drop the exiting one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_sum <= '0;
    end else if (flush) begin
      win_sum <= '0;
    end else if (en) begin
      win_sum <= win_sum + SW'(data_gated) - SW'(d[DEPTH-1]);
    end
  end
`endif

endmodule

// File: tb/tb_shift_reg_tap.sv
module tb_shift_reg_tap;
  localparam int W  = 7;
  localparam int D  = 5;
  localparam int TW = 3;
  localparam int CW = 3;

  logic          clk, rstn, en, flush, valid_in;
  logic [W-1:0]  data_in;
  logic [TW-1:0] tap_sel;
  logic [W-1:0]  data_out, tap_data;
  logic          valid_out, tap_valid, full;
  logic [CW-1:0] fill_cnt;
  logic [W+CW-1:0] act_sum;

`ifdef SHIFT_REG_TAP_SUM_EN
  logic [W+CW-1:0] win_sum;
  assign act_sum = win_sum;
`else
  assign act_sum = '0;
`endif

  shift_reg_tap #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .flush     (flush),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .tap_sel   (tap_sel),
    .data_out  (data_out),
    .valid_out (valid_out),
    .tap_data  (tap_data),
    .tap_valid (tap_valid),
    .fill_cnt  (fill_cnt),
    .full      (full)
`ifdef SHIFT_REG_TAP_SUM_EN
    ,
    .win_sum   (win_sum)
`endif
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    int              id;
    logic [W-1:0]    dout;
    logic            vout;
    logic [W-1:0]    tap;
    logic            tv;
    logic [CW-1:0]   fill;
    logic [W+CW-1:0] sum;
  } exp_t;

  exp_t q[$];
  exp_t m_x;
  int   n_vec = 0;
  int   n_err = 0;
  int   vid   = 0;

  // Drive one vector at the falling edge and queue its post-edge expectation.
  task automatic vec(input logic e, input logic f, input logic vi,
                     input logic [W-1:0] di, input logic [TW-1:0] ts,
                     input logic [W-1:0] ed, input logic ev,
                     input logic [W-1:0] et, input logic etv,
                     input logic [CW-1:0] ef, input logic [W+CW-1:0] es);
    exp_t x;
    @(negedge clk);
    en = e; flush = f; valid_in = vi; data_in = di; tap_sel = ts;
    vid++;
    x.id = vid; x.dout = ed; x.vout = ev; x.tap = et; x.tv = etv;
    x.fill = ef; x.sum = es;
    q.push_back(x);
  endtask

  // Monitor: one expectation consumed per clock the DUT presents a new state.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      logic ok;
      m_x = q.pop_front();
      ok = (data_out == m_x.dout) && (valid_out == m_x.vout) &&
           (tap_data == m_x.tap) && (tap_valid == m_x.tv) &&
           (fill_cnt == m_x.fill) && (full == (m_x.fill == CW'(D)));
`ifdef SHIFT_REG_TAP_SUM_EN
      ok = ok && (act_sum == m_x.sum);
`endif
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL vec%0d: got dout=%0d vout=%0d tap=%0d tv=%0d fill=%0d full=%0d sum=%0d want dout=%0d vout=%0d tap=%0d tv=%0d fill=%0d full=%0d sum=%0d",
                 m_x.id, data_out, valid_out, tap_data, tap_valid, fill_cnt, full, act_sum,
                 m_x.dout, m_x.vout, m_x.tap, m_x.tv, m_x.fill, (m_x.fill == CW'(D)), m_x.sum);
      end
    end
  end

  task automatic chk_zero(input string nm);
    n_vec++;
    if (data_out !== '0 || valid_out !== 1'b0 || tap_data !== '0 || tap_valid !== 1'b0 ||
        fill_cnt !== '0 || full !== 1'b0 || act_sum !== '0) begin
      n_err++;
      $display("FAIL %s: got dout=%0d vout=%0d tap=%0d tv=%0d fill=%0d full=%0d sum=%0d want all 0",
               nm, data_out, valid_out, tap_data, tap_valid, fill_cnt, full, act_sum);
    end
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; flush = 1'b0; valid_in = 1'b0; data_in = '0; tap_sel = '0;
    #12 chk_zero("reset");
    #3 rstn = 1'b1;

    // fill and latency: 3,1,5,11,15 then 21 while full (tap on stage 1)
    //   e f vi di ts  dout v tap tv fill sum
    vec(1,0,1, 3,1,   0,0,  0,0, 1,  3);
    vec(1,0,1, 1,1,   0,0,  3,1, 2,  4);
    vec(1,0,1, 5,1,   0,0,  1,1, 3,  9);
    vec(1,0,1,11,1,   0,0,  5,1, 4, 20);
    vec(1,0,1,15,1,   3,1, 11,1, 5, 35);
    vec(1,0,1,21,1,   1,1, 15,1, 5, 53);
    // stall with toggling input, then resume with the word present
    vec(0,0,1, 8,1,   1,1, 15,1, 5, 53);
    vec(0,0,1,11,1,   1,1, 15,1, 5, 53);
    vec(0,0,1,16,1,   1,1, 15,1, 5, 53);
    vec(1,0,1,16,1,   5,1, 21,1, 5, 68);
    // bubble walks through the taps; out-of-range tap reads zero
    vec(1,0,0, 9,0,  11,1,  0,0, 4, 63);
    vec(1,0,1, 2,1,  15,1,  0,0, 4, 54);
    vec(1,0,1, 4,6,  21,1,  0,0, 4, 43);
    vec(1,0,1, 6,3,  16,1,  0,0, 4, 28);
    vec(1,0,1, 7,4,   0,0,  0,0, 4, 19);
    vec(1,0,1,10,2,   2,1,  6,1, 5, 29);
    // flush when full discards the simultaneous word; flush also works with en=0
    vec(1,1,1, 9,0,   0,0,  0,0, 0,  0);
    vec(1,0,1, 9,0,   0,0,  9,1, 1,  9);
    vec(0,1,1, 3,0,   0,0,  0,0, 0,  0);
    // window sum sequence observed on the last-stage tap
    vec(1,0,1, 3,4,   0,0,  0,0, 1,  3);
    vec(1,0,1, 1,4,   0,0,  0,0, 2,  4);
    vec(1,0,1, 5,4,   0,0,  0,0, 3,  9);
    vec(1,0,1,11,4,   0,0,  0,0, 4, 20);
    vec(1,0,1,15,4,   3,1,  3,1, 5, 35);
    vec(1,0,1,21,4,   1,1,  1,1, 5, 53);
    vec(1,0,0,30,4,   5,1,  5,1, 4, 52);
    vec(1,0,0, 0,4,  11,1, 11,1, 3, 47);
    // asynchronous reset mid-stream, away from any clock edge
    @(posedge clk);
    #3 rstn = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk);
    rstn = 1'b1;
    vec(1,0,1,13,0,   0,0, 13,1, 1, 13);
    vec(0,1,1, 9,0,   0,0,  0,0, 0,  0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
